// File: rtl/nids_pkg.sv
// Shared definitions for the packet register-file write path.
//   NUM_THREADS : hardware threads sharing the register file
//   REG_ZERO    : destination that is acknowledged but never written
//   REG_HDR     : shared header-pointer register, one address for all threads
//   RF_AW       : register-file address width ({thread, rd})
//   wb_req_t    : write-back request record
//   rf_addr()   : forms the register-file address from thread and rd
package nids_pkg;

  localparam int         NUM_THREADS = 4;
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic [4:0] REG_HDR     = 5'd31;
  localparam int         RF_AW       = 7;
  localparam int         WB_DW       = 64;

  typedef struct packed {
    logic [1:0]       thread;
    logic [4:0]       rd;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_EOP,
    GNT_LD
  } gnt_e;

  // rd 31 maps to the single shared header-pointer slot regardless of thread.
  function automatic logic [RF_AW-1:0] rf_addr(input logic [1:0] thread,
                                               input logic [4:0] rd);
    return (rd == REG_HDR) ? RF_AW'(REG_HDR) : {thread, rd};
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO holding load returns until the write port is free.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push     : write wdata (ignored when full)
//   pop      : discard the head entry (ignored when empty)
//   wdata    : entry to store
//   rdata    : current head entry (valid when empty=0)
//   empty    : no entries stored
//   count    : number of stored entries, 0..DEPTH
module wb_load_fifo #(
  parameter int W     = 71,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side driver for the 4-thread x 32-entry packet register file.
// Merges ALU results, queued load returns and end-of-packet header-pointer
// updates into one registered write port, one write per cycle.
//   clk, rst                      : clock, asynchronous active-high reset
//   alu_valid/thread/rd/data      : ALU result (no backpressure)
//   ld_valid/thread/rd/data       : load return, accepted when ld_ready
//   ld_ready                      : load queue not full
//   pkt_done, pkt_hdr_ptr         : end-of-packet pulse and next header pointer
//   pkt_ready                     : no EOP pending; pkt_done while low is dropped
//   alu_stall                     : ALU must idle next cycle so a pending EOP can win
//   wen, waddr, din               : register-file write port
//   end_of_pkt, header_ptr        : header-pointer write strobe and value
//   eop_overrun                   : sticky, a pkt_done was dropped
module regfile_wb_ctrl
  import nids_pkg::*;
#(
  parameter int DW       = 64,
  parameter int LQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [1:0]       alu_thread,
  input  logic [4:0]       alu_rd,
  input  logic [DW-1:0]    alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [1:0]       ld_thread,
  input  logic [4:0]       ld_rd,
  input  logic [DW-1:0]    ld_data,
  input  logic             pkt_done,
  input  logic [7:0]       pkt_hdr_ptr,
  output logic             pkt_ready,
  output logic             alu_stall,
  output logic             wen,
  output logic [RF_AW-1:0] waddr,
  output logic [DW-1:0]    din,
  output logic             end_of_pkt,
  output logic [7:0]       header_ptr,
  output logic             eop_overrun
);

  localparam int QW = 7 + DW;
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic             eop_pending;
  logic [7:0]       eop_ptr;
  logic             ld_push;
  logic             ld_pop;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [QW-1:0]    ld_head;
  logic [1:0]       head_thread;
  logic [4:0]       head_rd;
  logic [DW-1:0]    head_data;
  gnt_e             gnt;

  logic             wen_p0;
  logic             eop_p0;
  logic [RF_AW-1:0] waddr_p0;
  logic [DW-1:0]    din_p0;
  logic [7:0]       hdr_p0;

  assign ld_ready  = (fifo_count != CW'(LQ_DEPTH));
  assign pkt_ready = ~eop_pending;
  assign ld_push   = ld_valid & ld_ready;
  assign ld_pop    = (gnt == GNT_LD);
  assign {head_thread, head_rd, head_data} = ld_head;

  wb_load_fifo #(
    .W     (QW),
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_push),
    .pop   (ld_pop),
    .wdata ({ld_thread, ld_rd, ld_data}),
    .rdata (ld_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p0: arbitration and write-port formation
  always_comb begin
    gnt = GNT_NONE;
    if (alu_valid)        gnt = GNT_ALU;
    else if (eop_pending) gnt = GNT_EOP;
    else if (!fifo_empty) gnt = GNT_LD;
  end

  always_comb begin
    wen_p0   = 1'b0;
    eop_p0   = 1'b0;
    waddr_p0 = '0;
    din_p0   = '0;
    hdr_p0   = '0;
    unique case (gnt)
      GNT_ALU: begin
        // rd 0 is consumed silently: the slot is used but nothing is written.
        if (alu_rd != REG_ZERO) begin
          wen_p0   = 1'b1;
          waddr_p0 = rf_addr(alu_thread, alu_rd);
          din_p0   = alu_data;
        end
      end
      GNT_EOP: begin
        eop_p0   = 1'b1;
        waddr_p0 = RF_AW'(REG_HDR);
        hdr_p0   = eop_ptr;
      end
      GNT_LD: begin
        if (head_rd != REG_ZERO) begin
          wen_p0   = 1'b1;
          waddr_p0 = rf_addr(head_thread, head_rd);
          din_p0   = head_data;
        end
      end
      default: ;
    endcase
  end

  // Stage p1: EOP bookkeeping and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eop_pending <= 1'b0;
      eop_ptr     <= '0;
      alu_stall   <= 1'b0;
      eop_overrun <= 1'b0;
      wen         <= 1'b0;
      end_of_pkt  <= 1'b0;
      waddr       <= '0;
      din         <= '0;
      header_ptr  <= '0;
    end else begin
      // Accepting a new packet and granting the pending one are exclusive:
      // acceptance needs eop_pending=0, the EOP grant needs eop_pending=1.
      if (pkt_done && !eop_pending) begin
        eop_pending <= 1'b1;
        eop_ptr     <= pkt_hdr_ptr;
      end else if (gnt == GNT_EOP) begin
        eop_pending <= 1'b0;
      end
      if (pkt_done && eop_pending) eop_overrun <= 1'b1;
      // Stalling the ALU for one cycle is enough for the EOP to win next.
      alu_stall  <= eop_pending & (gnt != GNT_EOP);
      wen        <= wen_p0;
      end_of_pkt <= eop_p0;
      waddr      <= waddr_p0;
      din        <= din_p0;
      header_ptr <= hdr_p0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl: vector table for single ALU writes, a
// scoreboard of expected register-file writes checked as they appear, and
// short directed sequences for EOP, load-queue and reset corner cases.
module tb_regfile_wb_ctrl;
  import nids_pkg::*;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [1:0]    alu_thread = '0;
  logic [4:0]    alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [1:0]    ld_thread = '0;
  logic [4:0]    ld_rd = '0;
  logic [DW-1:0] ld_data = '0;
  logic          pkt_done = 1'b0;
  logic [7:0]    pkt_hdr_ptr = '0;
  logic          pkt_ready;
  logic          alu_stall;
  logic          wen;
  logic [6:0]    waddr;
  logic [DW-1:0] din;
  logic          end_of_pkt;
  logic [7:0]    header_ptr;
  logic          eop_overrun;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DW(DW), .LQ_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_thread  (alu_thread),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_thread   (ld_thread),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .pkt_done    (pkt_done),
    .pkt_hdr_ptr (pkt_hdr_ptr),
    .pkt_ready   (pkt_ready),
    .alu_stall   (alu_stall),
    .wen         (wen),
    .waddr       (waddr),
    .din         (din),
    .end_of_pkt  (end_of_pkt),
    .header_ptr  (header_ptr),
    .eop_overrun (eop_overrun)
  );

  typedef struct {
    logic          eop;
    logic [6:0]    waddr;
    logic [DW-1:0] din;
    logic [7:0]    hp;
  } exp_t;

  typedef struct {
    logic [1:0]    thr;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic          exp_wen;
    logic [6:0]    exp_waddr;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[6];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [DW-1:0] d);
    sb.push_back('{eop: 1'b0, waddr: a, din: d, hp: 8'h00});
  endtask

  task automatic push_eop(input logic [7:0] p);
    sb.push_back('{eop: 1'b1, waddr: 7'd31, din: '0, hp: p});
  endtask

  // Presents one load and holds it until accepted; waits = cycles spent.
  task automatic do_load(input logic [1:0] thr, input logic [4:0] rd,
                         input logic [DW-1:0] d, input string nm, output int waits);
    logic acc;
    waits     = 0;
    acc       = 1'b0;
    ld_valid  = 1'b1;
    ld_thread = thr;
    ld_rd     = rd;
    ld_data   = d;
    do begin
      @(negedge clk);
      acc = ld_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!acc && waits < 50);
    ld_valid = 1'b0;
    chk({nm, "_accepted"}, {63'd0, acc}, 64'd1);
  endtask

  // Scoreboard: every write-port pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (wen || end_of_pkt)) begin
      chk("wr_exclusive", {63'd0, wen & end_of_pkt}, 64'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_eop", {63'd0, end_of_pkt}, {63'd0, mon_e.eop});
        chk("sb_waddr", {57'd0, waddr}, {57'd0, mon_e.waddr});
        if (mon_e.eop) chk("sb_hdr_ptr", {56'd0, header_ptr}, {56'd0, mon_e.hp});
        else           chk("sb_din", din, mon_e.din);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit eop_owed;

    vt[0] = '{2'd2, 5'd5,  64'hDEAD, 1'b1, 7'd69};
    vt[1] = '{2'd0, 5'd0,  64'h1111, 1'b0, 7'd0};
    vt[2] = '{2'd3, 5'd31, 64'h2222, 1'b1, 7'd31};
    vt[3] = '{2'd1, 5'd1,  64'h3333, 1'b1, 7'd33};
    vt[4] = '{2'd3, 5'd30, 64'h4444, 1'b1, 7'd126};
    vt[5] = '{2'd2, 5'd0,  64'h5555, 1'b0, 7'd0};

    // Reset and idle
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_end_of_pkt", {63'd0, end_of_pkt}, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_pkt_ready", {63'd0, pkt_ready}, 64'd1);
    chk("rst_alu_stall", {63'd0, alu_stall}, 64'd0);
    chk("rst_eop_overrun", {63'd0, eop_overrun}, 64'd0);

    // Single ALU writes from the vector table
    for (int i = 0; i < 6; i++) begin
      alu_valid  = 1'b1;
      alu_thread = vt[i].thr;
      alu_rd     = vt[i].rd;
      alu_data   = vt[i].data;
      if (vt[i].exp_wen) push_wr(vt[i].exp_waddr, vt[i].data);
      tick();
      alu_valid = 1'b0;
      chk($sformatf("vec%0d_wen", i), {63'd0, wen}, {63'd0, vt[i].exp_wen});
      if (vt[i].exp_wen) begin
        chk($sformatf("vec%0d_waddr", i), {57'd0, waddr}, {57'd0, vt[i].exp_waddr});
        chk($sformatf("vec%0d_din", i), din, vt[i].data);
      end
      tick();
      chk($sformatf("vec%0d_wen_one_cycle", i), {63'd0, wen}, 64'd0);
    end
    repeat (2) tick();
    chk("vec_drained", 64'(sb.size()), 64'd0);

    // Continuous ALU traffic with an EOP: the ALU obeys alu_stall
    eop_owed = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t3_alu_stall_c%0d", c), {63'd0, alu_stall}, {63'd0, (c == 4)});
      if (alu_stall) begin
        alu_valid = 1'b0;
        if (eop_owed) begin
          push_eop(8'h2A);
          eop_owed = 1'b0;
        end
      end else begin
        alu_valid  = 1'b1;
        alu_thread = 2'(c);
        alu_rd     = 5'(c + 1);
        alu_data   = 64'(c) + 64'h100;
        push_wr({2'(c), 5'(c + 1)}, 64'(c) + 64'h100);
      end
      pkt_done    = (c == 2);
      pkt_hdr_ptr = 8'h2A;
      if (c == 2) eop_owed = 1'b1;
      tick();
      pkt_done = 1'b0;
    end
    alu_valid = 1'b0;
    repeat (3) tick();
    chk("t3_drained", 64'(sb.size()), 64'd0);
    chk("t3_pkt_ready", {63'd0, pkt_ready}, 64'd1);

    // rd 0 produces no write; rd 31 maps to the shared slot
    alu_valid  = 1'b1;
    alu_thread = 2'd3;
    alu_rd     = 5'd0;
    alu_data   = 64'hBAD0;
    tick();
    alu_valid = 1'b0;
    do_load(2'd2, 5'd0, 64'hBAD1, "t4_ld_rd0", w);
    push_wr(7'd31, 64'h77);
    do_load(2'd1, 5'd31, 64'h77, "t4_ld_rd31", w);
    repeat (4) tick();
    chk("t4_drained", 64'(sb.size()), 64'd0);

    // Queue fills behind a long ALU burst; loads drain in order afterwards
    for (int k = 0; k < 6; k++) push_wr(7'(10 + k), 64'hA0 + 64'(k));
    for (int k = 0; k < 5; k++) push_wr(7'(52 + k), 64'hB0 + 64'(k));
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          alu_valid  = 1'b1;
          alu_thread = 2'd0;
          alu_rd     = 5'(10 + k);
          alu_data   = 64'hA0 + 64'(k);
          tick();
        end
        alu_valid = 1'b0;
      end
      begin
        int lw;
        for (int k = 0; k < 5; k++) begin
          do_load(2'd1, 5'(20 + k), 64'hB0 + 64'(k), $sformatf("t5_ld%0d", k), lw);
          if (k == 3) chk("t5_ld_ready_full", {63'd0, ld_ready}, 64'd0);
          if (k == 4) chk("t5_ld4_waits", 64'(lw), 64'd4);
        end
      end
    join
    repeat (8) tick();
    chk("t5_drained", 64'(sb.size()), 64'd0);
    chk("t5_ld_ready_empty", {63'd0, ld_ready}, 64'd1);

    // Back-to-back pkt_done: the second is dropped
    pkt_done    = 1'b1;
    pkt_hdr_ptr = 8'h11;
    push_eop(8'h11);
    tick();
    chk("t6_pkt_ready_low", {63'd0, pkt_ready}, 64'd0);
    pkt_hdr_ptr = 8'h22;
    tick();
    pkt_done = 1'b0;
    chk("t6_eop_overrun", {63'd0, eop_overrun}, 64'd1);
    repeat (4) tick();
    chk("t6_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with loads queued and an ALU write on the port
    alu_valid  = 1'b1;
    alu_thread = 2'd1;
    alu_rd     = 5'd3;
    alu_data   = 64'hC0;
    ld_valid   = 1'b1;
    ld_thread  = 2'd2;
    ld_rd      = 5'd4;
    ld_data    = 64'hD0;
    push_wr(7'd35, 64'hC0);
    tick();
    alu_data = 64'hC1;
    tick();
    chk("t7_wen_before_rst", {63'd0, wen}, 64'd1);
    rst       = 1'b1;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    sb.delete();
    chk("t7_rst_wen", {63'd0, wen}, 64'd0);
    chk("t7_rst_waddr", {57'd0, waddr}, 64'd0);
    chk("t7_rst_din", din, 64'd0);
    chk("t7_rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("t7_rst_pkt_ready", {63'd0, pkt_ready}, 64'd1);
    chk("t7_rst_overrun", {63'd0, eop_overrun}, 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("t7_post_rst_wen", {63'd0, wen}, 64'd0);
    chk("t7_post_rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
